mem_wb_stage: RTL and testbench

//  MEM->WB pipeline register for the RV32I core. Latches the memory-stage results,

---
 rtl/mem_wb_stage.sv | 111 +++++++++++
 tb/tb_mem_wb_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register for the RV32I core: load byte/halfword extraction and
// extension, the four writeback mux candidates with select lines, and a retire counter.
module mem_wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  imm,
  input  logic [2:0]       funct3,
  input  logic             is_load,
  input  logic [4:0]       rd_addr,
  input  logic             reg_write,
  input  logic             sel_op,
  input  logic [1:0]       sel_port,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic             wb_sel_op,
  output logic [1:0]       wb_sel_port,
  output logic [XLEN-1:0]  wb_port0,
  output logic [XLEN-1:0]  wb_port1,
  output logic [XLEN-1:0]  wb_port2,
  output logic [XLEN-1:0]  wb_port3,
  output logic             load_fault,
  output logic [CNT_W-1:0] retire_count
);

  localparam int unsigned BW = 8;
  localparam int unsigned HW = 16;

  logic [BW-1:0]   byte_c;
  logic [HW-1:0]   half_c;
  logic [XLEN-1:0] ld_data_c;
  logic            fault_c;

  // Lane selection from the low address bits.
  always_comb begin
    byte_c = mem_rdata[7:0];
    case (alu_result[1:0])
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      2'd3:    byte_c = mem_rdata[31:24];
      default: byte_c = mem_rdata[7:0];
    endcase
    half_c = alu_result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Size/sign decode; a faulting load returns zero so nothing stale reaches WB.
  always_comb begin
    ld_data_c = mem_rdata;
    fault_c   = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000:  ld_data_c = {{(XLEN-BW){byte_c[BW-1]}}, byte_c};
        3'b100:  ld_data_c = {{(XLEN-BW){1'b0}}, byte_c};
        3'b001: begin
          ld_data_c = {{(XLEN-HW){half_c[HW-1]}}, half_c};
          fault_c   = alu_result[0];
        end
        3'b101: begin
          ld_data_c = {{(XLEN-HW){1'b0}}, half_c};
          fault_c   = alu_result[0];
        end
        3'b010:  fault_c = |alu_result[1:0];
        default: fault_c = 1'b1;
      endcase
      if (fault_c) ld_data_c = '0;
    end
  end

  // Pipeline register: flush > stall > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_sel_op    <= 1'b0;
      wb_sel_port  <= '0;
      wb_port0     <= '0;
      wb_port1     <= '0;
      wb_port2     <= '0;
      wb_port3     <= '0;
      load_fault   <= 1'b0;
      retire_count <= '0;
    end else if (flush) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      load_fault   <= 1'b0;
    end else if (!stall) begin
      wb_valid     <= in_valid;
      wb_rd        <= rd_addr;
      wb_reg_write <= in_valid & reg_write & ~fault_c;
      wb_sel_op    <= sel_op;
      wb_sel_port  <= sel_port;
      wb_port0     <= alu_result;
      wb_port1     <= ld_data_c;
      wb_port2     <= pc_plus4;
      wb_port3     <= imm;
      load_fault   <= in_valid & fault_c;
      retire_count <= retire_count + CNT_W'(in_valid);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a spec-level model, plus literal checks
// of the documented scenarios; a narrow-counter instance exercises retire wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] alu_result = '0, mem_rdata = '0, pc_plus4 = '0, imm = '0;
  logic [2:0]  funct3 = '0;
  logic        is_load = 1'b0, reg_write = 1'b0, sel_op = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [1:0]  sel_port = '0;

  logic        wb_valid, wb_reg_write, wb_sel_op, load_fault;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel_port;
  logic [31:0] wb_port0, wb_port1, wb_port2, wb_port3, retire_count;

  logic        s_valid, s_reg_write, s_sel_op, s_fault;
  logic [4:0]  s_rd;
  logic [1:0]  s_sel_port;
  logic [31:0] s_p0, s_p1, s_p2, s_p3;
  logic [2:0]  s_retire;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .imm(imm),
    .funct3(funct3), .is_load(is_load), .rd_addr(rd_addr), .reg_write(reg_write),
    .sel_op(sel_op), .sel_port(sel_port), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_sel_op(wb_sel_op), .wb_sel_port(wb_sel_port),
    .wb_port0(wb_port0), .wb_port1(wb_port1), .wb_port2(wb_port2), .wb_port3(wb_port3),
    .load_fault(load_fault), .retire_count(retire_count)
  );

  mem_wb_stage #(.XLEN(32), .CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .imm(imm),
    .funct3(funct3), .is_load(is_load), .rd_addr(rd_addr), .reg_write(reg_write),
    .sel_op(sel_op), .sel_port(sel_port), .wb_valid(s_valid), .wb_rd(s_rd),
    .wb_reg_write(s_reg_write), .wb_sel_op(s_sel_op), .wb_sel_port(s_sel_port),
    .wb_port0(s_p0), .wb_port1(s_p1), .wb_port2(s_p2), .wb_port3(s_p3),
    .load_fault(s_fault), .retire_count(s_retire)
  );

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference load extraction: shift the addressed lane down, mask, extend arithmetically.
  function automatic void ref_load(input logic [31:0] addr, input logic [31:0] rdata,
                                   input logic [2:0] f3, input logic ld,
                                   output logic [31:0] d, output logic flt);
    int unsigned off;
    logic [31:0] lane;
    off  = addr % 4;
    lane = rdata >> (8 * off);
    d    = rdata;
    flt  = 1'b0;
    if (ld) begin
      case (f3)
        3'd0: d = (lane & 32'hFF) >= 32'h80 ? (lane & 32'hFF) - 32'h100 : lane & 32'hFF;
        3'd4: d = lane & 32'hFF;
        3'd1: begin flt = (off % 2) != 0; d = (lane & 32'hFFFF) >= 32'h8000 ?
                                               (lane & 32'hFFFF) - 32'h10000 : lane & 32'hFFFF; end
        3'd5: begin flt = (off % 2) != 0; d = lane & 32'hFFFF; end
        3'd2: flt = off != 0;
        default: flt = 1'b1;
      endcase
      if (flt) d = 32'h0;
    end
  endfunction

  // Behavioural model state
  logic        m_valid = 0, m_rw = 0, m_sel_op = 0, m_fault = 0, m_known = 1;
  logic [4:0]  m_rd = 0;
  logic [1:0]  m_sel_port = 0;
  logic [31:0] m_p0 = 0, m_p1 = 0, m_p2 = 0, m_p3 = 0;
  int unsigned m_cnt = 0, m_cnt_s = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] d;
    logic flt;
    if (!rst_n) begin
      m_valid = 0; m_rw = 0; m_sel_op = 0; m_fault = 0; m_known = 1; m_rd = 0;
      m_sel_port = 0; m_p0 = 0; m_p1 = 0; m_p2 = 0; m_p3 = 0; m_cnt = 0; m_cnt_s = 0;
    end else if (flush) begin
      m_valid = 0; m_rw = 0; m_fault = 0; m_known = 0;
    end else if (!stall) begin
      ref_load(alu_result, mem_rdata, funct3, is_load, d, flt);
      m_valid = in_valid; m_rd = rd_addr; m_sel_op = sel_op; m_sel_port = sel_port;
      m_rw = in_valid && reg_write && !flt; m_fault = in_valid && flt;
      m_p0 = alu_result; m_p1 = d; m_p2 = pc_plus4; m_p3 = imm; m_known = 1;
      if (in_valid) begin m_cnt = m_cnt + 1; m_cnt_s = (m_cnt_s + 1) % 8; end
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    chk("wb_valid", 64'(wb_valid), 64'(m_valid));
    chk("wb_reg_write", 64'(wb_reg_write), 64'(m_rw));
    chk("load_fault", 64'(load_fault), 64'(m_fault));
    chk("retire_count", 64'(retire_count), 64'(m_cnt));
    chk("small_retire", 64'(s_retire), 64'(m_cnt_s));
    chk("small_valid", 64'(s_valid), 64'(m_valid));
    if (m_known) begin
      chk("wb_rd", 64'(wb_rd), 64'(m_rd));
      chk("wb_sel_op", 64'(wb_sel_op), 64'(m_sel_op));
      chk("wb_sel_port", 64'(wb_sel_port), 64'(m_sel_port));
      chk("wb_port0", 64'(wb_port0), 64'(m_p0));
      chk("wb_port1", 64'(wb_port1), 64'(m_p1));
      chk("wb_port2", 64'(wb_port2), 64'(m_p2));
      chk("wb_port3", 64'(wb_port3), 64'(m_p3));
    end
  end

  task automatic drive(input logic v, input logic ld, input logic rw, input logic st,
                       input logic fl, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdat);
    in_valid = v; is_load = ld; reg_write = rw; stall = st; flush = fl; funct3 = f3;
    alu_result = alu; mem_rdata = rdat; pc_plus4 = alu + 32'd4; imm = ~alu;
    rd_addr = 5'd7; sel_op = 1'b1; sel_port = 2'd1;
    @(negedge clk);
  endtask

  task automatic drive_rand();
    in_valid   = ($urandom_range(0, 9) < 8);
    stall      = ($urandom_range(0, 9) < 2);
    flush      = ($urandom_range(0, 19) == 0);
    is_load    = $urandom_range(0, 1) != 0;
    reg_write  = $urandom_range(0, 3) != 0;
    funct3     = 3'($urandom_range(0, 7));
    alu_result = $urandom;
    mem_rdata  = $urandom;
    pc_plus4   = $urandom;
    imm        = $urandom;
    rd_addr    = 5'($urandom_range(0, 31));
    sel_op     = $urandom_range(0, 1) != 0;
    sel_port   = 2'($urandom_range(0, 3));
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(wb_valid), 64'd0);
    chk("reset_count", 64'(retire_count), 64'd0);
    rst_n = 1'b1;

    drive(1, 1, 1, 0, 0, 3'b000, 32'h1003, 32'h80FF_1234);
    chk("lb_data", 64'(wb_port1), 64'hFFFF_FF80);
    chk("lb_rw", 64'(wb_reg_write), 64'd1);
    drive(1, 1, 1, 0, 0, 3'b100, 32'h1003, 32'h80FF_1234);
    chk("lbu_data", 64'(wb_port1), 64'h0000_0080);
    drive(1, 1, 1, 0, 0, 3'b001, 32'h1001, 32'h80FF_1234);
    chk("lh_fault", 64'(load_fault), 64'd1);
    chk("lh_data", 64'(wb_port1), 64'd0);
    chk("lh_rw", 64'(wb_reg_write), 64'd0);
    chk("lh_valid", 64'(wb_valid), 64'd1);
    chk("lh_count", 64'(retire_count), 64'd3);
    drive(1, 0, 1, 0, 0, 3'b000, 32'h5, 32'hDEAD_BEEF);
    chk("add_p0", 64'(wb_port0), 64'h5);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 0, 3'b010, 32'h99 + 32'(i), 32'h1111_0000);
      chk("stall_p0", 64'(wb_port0), 64'h5);
      chk("stall_count", 64'(retire_count), 64'd4);
    end
    drive(1, 0, 1, 1, 1, 3'b000, 32'h77, 32'h0);
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_rw", 64'(wb_reg_write), 64'd0);
    chk("flush_count", 64'(retire_count), 64'd4);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 0, 3'b000, 32'h40, 32'h0);
    chk("wrap_small", 64'(s_retire), 64'd0);
    chk("count_8", 64'(retire_count), 64'd8);

    repeat (2000) drive_rand();

    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(wb_valid), 64'd0);
    chk("midrst_p0", 64'(wb_port0), 64'd0);
    chk("midrst_p1", 64'(wb_port1), 64'd0);
    chk("midrst_fault", 64'(load_fault), 64'd0);
    chk("midrst_count", 64'(retire_count), 64'd0);
    #2 rst_n = 1'b1;

    repeat (500) drive_rand();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
